cic_comb_chain: RTL
===================

# cic_comb_chain

Comb section of the CIC decimation filter, placed directly downstream of the decimating rate changer. It accepts full-precision two's-complement samples at the decimated rate, marked by a one-cycle strobe in the `clk_fast` domain. It applies N cascaded comb stages, each computing `y[n] = x[n] - x[n-M]`, and emits the filtered sample with a matching strobe. A `primed` flag marks when the start-up transient has flushed.

## Interface
- `WIDTH`, 8: sample width in bits. It is already the full CIC register width, so no bit growth occurs here.
- `STAGES`, 3: number of comb stages N, at least 1.
- `DIFF_DELAY`, 1: differential delay M, either 1 or 2.
- `clk_fast` input 1: single clock for the block.
- `rstn` input 1: reset. Asynchronous, active-low.
- `in_valid` input 1: one-cycle strobe marking a new decimated sample on `in_data`.
- `in_data` input WIDTH: signed input sample.
- `out_valid` output 1: one-cycle strobe marking a new result on `out_data`.
- `out_data` output WIDTH: signed comb-chain output. Holds its value between strobes.
- `primed` output 1: high once the pipeline has emitted at least N·M outputs since reset. Sticky.

## Operation
- **Stage k (0..N-1)**
  - Input is the stage k-1 output, or `in_data` for k=0.
  - When its input strobe is high, the stage registers `x - d[M-1]` into its output register.
  - On the same cycle it shifts `x` into its M-deep delay line `d[0..M-1]`.
  - It then pulses its own valid one cycle later.
- **Arithmetic**
  - Modular two's-complement subtraction at WIDTH bits. Wrap-around is intentional and required for CIC correctness.
  - No saturation and no overflow flag.
- **Delay lines**
  - Advance only on their stage's strobe, never on idle cycles.
  - Sample spacing is therefore independent of the strobe period.
- **Throughput:** `in_valid` may be high on consecutive cycles; every strobe is processed. There is no backpressure.
- **Prime counter**
  - Width `$clog2(STAGES*DIFF_DELAY+1)`.
  - Increments on each `out_valid` until it reaches N·M, then saturates.
  - `primed` = (count == N·M).
- **Reset**
  - Asynchronously clears all stage outputs, delay lines, valid pipeline bits and the prime counter.
  - Reset values: `out_valid`=0, `out_data`=0, `primed`=0.
  - A reset mid-operation discards any in-flight samples. No strobe is produced for them after release.
- **First samples after reset:** delay lines read as 0, so the first outputs are the transient and are emitted with `out_valid` high.

## Timing
- **Latency:** `in_valid` at cycle t gives `out_valid` at t+N, exactly one register per stage.
- `out_data` changes only on the cycle `out_valid` is high. Otherwise it holds.
- **Strobes in flight:** strobes at t and t+1 yield outputs at t+N and t+N+1. Pipeline valid bits never merge or drop.
- **Reset release:** `in_valid` sampled on the first rising edge after `rstn` deasserts is accepted.
- **`primed` timing:** rises in the same cycle as the N·M-th `out_valid` (combinational on the updated count register, i.e. registered together with `out_valid`).

## Structure
- **Shared package `cic_pkg`**
  - Parameter-legality function: STAGES ≥ 1, DIFF_DELAY ∈ {1,2}.
  - Prime-count width helper.
  - Shared with the integrator and rate-changer blocks.
- **Sub-module `cic_comb_stage`** (`WIDTH`, `DIFF_DELAY`)
  - Contains one delay line, one subtractor, the output register and the valid flop.
  - `cic_comb_chain` instantiates it STAGES times in a generate loop and adds the prime counter.

## Test plan
- **Impulse:** N=3, M=1, WIDTH=8, input 1 then 0,0,0,0.
  - Outputs 1, -3, 3, -1, 0, each `out_valid` exactly 3 cycles after its `in_valid`.
- **Step:** N=3, M=1, constant input 5 for 6 samples.
  - Outputs 5, -10, 5, 0, 0, 0.
  - `primed` rises with the 3rd output.
- **Wrap:** N=1, M=1, WIDTH=8, inputs 127 then -128.
  - Outputs 127 then 1, the modular result of -255.
- **Differential delay:** N=1, M=2, inputs 4, 7, 9.
  - Outputs 4, 7, 5.
  - `primed` rises with the 2nd output.
- **Back-to-back strobes:** `in_valid` high 4 consecutive cycles, then strobes every 4th cycle.
  - Output strobe pattern equals the input pattern shifted by N.
  - Values match the golden model.
- **Reset mid-flight:** assert `rstn`=0 while 2 samples are in the pipeline.
  - All outputs are 0 and `primed`=0 during reset.
  - No `out_valid` after release until a new `in_valid` arrives.
  - The next impulse reproduces the reset-state impulse response.

Source files
------------

// File: rtl/cic_pkg.sv
// cic_pkg: parameter checks and sizing helpers shared by the CIC filter blocks
package cic_pkg;

  function automatic bit params_ok(int stages, int diff_delay);
    return stages >= 1 && (diff_delay == 1 || diff_delay == 2);
  endfunction

  function automatic int prime_w(int stages, int diff_delay);
    return $clog2(stages * diff_delay + 1);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one comb y[n] = x[n] - x[n-M] with an M-deep strobe-gated delay line
module cic_comb_stage #(
  parameter int WIDTH      = 8,
  parameter int DIFF_DELAY = 1
) (
  input  logic             clk_fast,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] d [DIFF_DELAY];

  // subtract the oldest sample and shift the delay line, only on the input strobe
  always_ff @(posedge clk_fast or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < DIFF_DELAY; i++) d[i] <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data - d[DIFF_DELAY-1];
        d[0]     <= in_data;
        for (int i = 1; i < DIFF_DELAY; i++) d[i] <= d[i-1];
      end
    end

endmodule

// File: rtl/cic_comb_chain.sv
// cic_comb_chain: N cascaded comb stages with a sticky start-up transient flag
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STAGES     = 3,
  parameter int DIFF_DELAY = 1
) (
  input  logic             clk_fast,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             primed
);

  localparam int PW  = prime_w(STAGES, DIFF_DELAY);
  localparam int TGT = STAGES * DIFF_DELAY;

  logic [STAGES:0]  vld;
  logic [WIDTH-1:0] data [STAGES+1];
  logic [PW-1:0]    cnt;

  assign vld[0]  = in_valid;
  assign data[0] = in_data;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    cic_comb_stage #(.WIDTH(WIDTH), .DIFF_DELAY(DIFF_DELAY)) u_stage (
      .clk_fast  (clk_fast),
      .rstn      (rstn),
      .in_valid  (vld[g]),
      .in_data   (data[g]),
      .out_valid (vld[g+1]),
      .out_data  (data[g+1])
    );
  end

  // count on the last stage's input strobe so the count lands with out_valid
  always_ff @(posedge clk_fast or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (vld[STAGES-1] && cnt != PW'(TGT)) cnt <= cnt + PW'(1);

  assign out_valid = vld[STAGES];
  assign out_data  = data[STAGES];
  assign primed    = cnt == PW'(TGT);

  // illegal stage count or differential delay
  always_ff @(posedge clk_fast)
    assert (params_ok(STAGES, DIFF_DELAY));

endmodule
